// File: rtl/crc_codec_arb_if.sv
// Requester-side bundle for crc_codec_arb: two job ports plus the shared result bus.
interface crc_codec_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_data;
  logic        req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_data;
  logic        req1_mode;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [15:0] rsp_data;

  modport master (
    output req0_valid, req0_data, req0_mode,
    output req1_valid, req1_data, req1_mode,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_mode,
    input  req1_valid, req1_data, req1_mode,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/crc_codec_arb.sv
// Two-port arbiter feeding a free-running 9-cycle CRC codec frame, with result routing by tag.
// Optional statistics counters are enabled by defining CRC_CODEC_ARB_STAT_EN.
module crc_codec_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  crc_codec_arb_if.slave        bus,
  output logic                  cdc_rst_n,
  output logic                  cdc_valid,
  output logic [15:0]           cdc_data,
  output logic                  cdc_mode,
  input  logic [15:0]           cdc_data_o,
  input  logic                  cdc_valid_o,
  output logic                  sync_err
`ifdef CRC_CODEC_ARB_STAT_EN
  ,
  output logic [15:0]           stat_jobs0,
  output logic [15:0]           stat_jobs1,
  output logic [15:0]           stat_idle
`endif
);
  typedef enum logic [1:0] {TAG_NONE, TAG_P0, TAG_P1} tag_e;

  logic [3:0]  fcnt_q, fcnt_d;
  tag_e        cur_tag_q, cur_tag_d, done_tag_q, done_tag_d;
  logic        last_q, last_d;
  logic [15:0] data_q, data_d;
  logic        mode_q, mode_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;

  logic        any_v, win, slot, grant, dummy;
  logic        rdy0, rdy1, rv0, rv1;
  logic [15:0] rdat;

  always_comb begin
    fcnt_d     = fcnt_q;
    cur_tag_d  = cur_tag_q;
    done_tag_d = done_tag_q;
    last_d     = last_q;
    data_d     = data_q;
    mode_d     = mode_q;
    wrap_d     = 1'b0;
    err_d      = err_q;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    rv0        = 1'b0;
    rv1        = 1'b0;
    rdat       = '0;
    cdc_valid  = 1'b0;
    grant      = 1'b0;
    dummy      = 1'b0;

    any_v = bus.req0_valid | bus.req1_valid;
    slot  = (fcnt_q == 4'd0) || (fcnt_q == 4'd9);
    if (bus.req0_valid && bus.req1_valid) win = FIXED_PRIO ? 1'b0 : ~last_q;
    else                                  win = bus.req1_valid;

    if (!rst) begin
      grant     = slot && any_v;
      dummy     = (fcnt_q == 4'd9) && !any_v;
      rdy0      = grant && !win;
      rdy1      = grant && win;
      cdc_valid = (fcnt_q == 4'd0) && any_v;
      // Results arrive one cycle after the wrap and belong to the frame that just ended.
      if (fcnt_q == 4'd1 && cdc_valid_o) begin
        rv0 = (done_tag_q == TAG_P0);
        rv1 = (done_tag_q == TAG_P1);
      end
      if (rv0 || rv1) rdat = cdc_data_o;
    end

    if (fcnt_q == 4'd9) begin
      fcnt_d     = 4'd1;
      wrap_d     = 1'b1;
      done_tag_d = cur_tag_q;
      cur_tag_d  = TAG_NONE;
    end else if (fcnt_q == 4'd0) begin
      if (any_v) fcnt_d = 4'd1;
    end else begin
      fcnt_d = fcnt_q + 4'd1;
    end

    if (grant) begin
      data_d    = win ? bus.req1_data : bus.req0_data;
      mode_d    = win ? bus.req1_mode : bus.req0_mode;
      cur_tag_d = win ? TAG_P1 : TAG_P0;
      last_d    = win;
    end else if (dummy) begin
      data_d = '0;
      mode_d = 1'b0;
    end

    if ((cdc_valid_o && fcnt_q != 4'd1) || (fcnt_q == 4'd1 && wrap_q && !cdc_valid_o))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q     <= '0;
      cur_tag_q  <= TAG_NONE;
      done_tag_q <= TAG_NONE;
      last_q     <= 1'b1;
      data_q     <= '0;
      mode_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      cur_tag_q  <= cur_tag_d;
      done_tag_q <= done_tag_d;
      last_q     <= last_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp0_valid = rv0;
  assign bus.rsp1_valid = rv1;
  assign bus.rsp_data   = rdat;
  assign cdc_rst_n      = ~rst;
  assign cdc_data       = data_q;
  assign cdc_mode       = mode_q;
  assign sync_err       = err_q;

`ifdef CRC_CODEC_ARB_STAT_EN
  logic [15:0] sj0_q, sj0_d, sj1_q, sj1_d, sid_q, sid_d;

  always_comb begin
    sj0_d = sj0_q;
    sj1_d = sj1_q;
    sid_d = sid_q;
    if (rv0 && sj0_q != '1)   sj0_d = sj0_q + 16'd1;
    if (rv1 && sj1_q != '1)   sj1_d = sj1_q + 16'd1;
    if (dummy && sid_q != '1) sid_d = sid_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sj0_q <= '0;
      sj1_q <= '0;
      sid_q <= '0;
    end else begin
      sj0_q <= sj0_d;
      sj1_q <= sj1_d;
      sid_q <= sid_d;
    end
  end

  assign stat_jobs0 = sj0_q;
  assign stat_jobs1 = sj1_q;
  assign stat_idle  = sid_q;
`endif
endmodule

// File: tb/tb_crc_codec_arb.sv
// Directed bench for crc_codec_arb with a behavioural CRC-8 (poly 0x07) codec model.
module tb_crc_codec_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        cdc_rst_n, cdc_valid, cdc_mode, cdc_valid_o, sync_err;
  logic [15:0] cdc_data, cdc_data_o;
  logic        force_vo;
  logic [3:0]  mcnt;
  logic        mvo;
  logic [15:0] mdo;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_codec_arb_if bus();

`ifdef CRC_CODEC_ARB_STAT_EN
  logic [15:0] stat_jobs0, stat_jobs1, stat_idle;
`endif

  crc_codec_arb #(.FIXED_PRIO(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cdc_rst_n   (cdc_rst_n),
    .cdc_valid   (cdc_valid),
    .cdc_data    (cdc_data),
    .cdc_mode    (cdc_mode),
    .cdc_data_o  (cdc_data_o),
    .cdc_valid_o (cdc_valid_o),
    .sync_err    (sync_err)
`ifdef CRC_CODEC_ARB_STAT_EN
    ,
    .stat_jobs0  (stat_jobs0),
    .stat_jobs1  (stat_jobs1),
    .stat_idle   (stat_idle)
`endif
  );

  function automatic logic [7:0] crc8(input logic [7:0] m);
    logic [7:0] c;
    c = m;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [15:0] codec_fn(input logic [15:0] d, input logic mode);
    logic [15:0] t;
    if (mode) return {d[15:8], crc8(d[15:8])};
    if (crc8(d[15:8]) == d[7:0]) return d;
    for (int i = 0; i < 16; i++) begin
      t = d ^ (16'h0001 << i);
      if (crc8(t[15:8]) == t[7:0]) return t;
    end
    return d;
  endfunction

  // Codec model: own frame counter, result presented one cycle after each 9->1 wrap.
  always @(posedge clk) begin
    if (!cdc_rst_n) begin
      mcnt <= '0;
      mvo  <= 1'b0;
      mdo  <= '0;
    end else begin
      mvo <= 1'b0;
      if (mcnt == 4'd0) begin
        if (cdc_valid) mcnt <= 4'd1;
      end else if (mcnt == 4'd9) begin
        mcnt <= 4'd1;
        mvo  <= 1'b1;
        mdo  <= codec_fn(cdc_data, cdc_mode);
      end else begin
        mcnt <= mcnt + 4'd1;
      end
    end
  end
  assign cdc_valid_o = mvo | force_vo;
  assign cdc_data_o  = mdo;

  typedef struct {
    int          port;
    logic        mode;
    logic [15:0] data;
    logic [15:0] exp;
  } job_t;

  job_t jobs[6];
  int   goff[7] = '{0, 9, 18, 27, 36, 45, 90};
  int   gprt[7] = '{0, 1, 0, 1, 0, 1, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic m, input logic [15:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_mode = m; bus.req0_data = d;
    end else begin
      bus.req1_valid = v; bus.req1_mode = m; bus.req1_data = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0);
    #1;
    chk("rst_cdc_rst_n", 32'(cdc_rst_n), 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_job(input job_t j, input logic first);
    int   w;
    logic got, early;
    set_req(j.port, 1'b1, j.mode, j.data);
    #1;
    got = 1'b0;
    w   = 0;
    while (!got && w < 30) begin
      if (rdy(j.port)) got = 1'b1;
      else begin tick(); #1; w++; end
    end
    chk("job_grant", 32'(got), 32'd1);
    chk("job_excl_ready", 32'(rdy(1 - j.port)), 32'd0);
    if (first) begin
      chk("launch_wait", 32'(w), 32'd0);
      chk("launch_cdc_valid", 32'(cdc_valid), 32'd1);
    end
    tick();
    set_req(j.port, 1'b0, 1'b0, 16'h0);
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (k == 1) begin
        chk("cdc_data_load", 32'(cdc_data), 32'(j.data));
        chk("cdc_mode_load", 32'(cdc_mode), 32'(j.mode));
      end
      if (k == 9) chk("cdc_data_hold", 32'(cdc_data), 32'(j.data));
      if (k < 10) begin
        if (bus.rsp0_valid || bus.rsp1_valid) early = 1'b1;
        tick();
      end
    end
    chk("job_no_early_rsp", 32'(early), 32'd0);
    chk("job_rsp_valid", 32'(rspv(j.port)), 32'd1);
    chk("job_rsp_other", 32'(rspv(1 - j.port)), 32'd0);
    chk("job_rsp_data", 32'(bus.rsp_data), 32'(j.exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          ng, nr, g0, g, g2, quiet, rsp0_cnt, rsp1_cyc, upd_p;
    logic        upd;
    logic [7:0]  n0, n1, msg;
    logic [15:0] r1dat;
    int          ecyc[$];
    int          eprt[$];
    logic [15:0] edat[$];

    jobs[0] = '{port: 0, mode: 1'b1, data: 16'hA500, exp: 16'hA572};
    jobs[1] = '{port: 1, mode: 1'b0, data: 16'hB572, exp: 16'hA572};
    jobs[2] = '{port: 0, mode: 1'b0, data: 16'hA572, exp: 16'hA572};
    jobs[3] = '{port: 1, mode: 1'b1, data: 16'h0100, exp: 16'h0107};
    jobs[4] = '{port: 0, mode: 1'b1, data: 16'h8000, exp: 16'h8089};
    jobs[5] = '{port: 1, mode: 1'b0, data: 16'h8088, exp: 16'h8089};

    force_vo = 1'b0;
    do_reset();
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_cdc_valid", 32'(cdc_valid), 32'd0);
    chk("rst_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_cdc_data", 32'(cdc_data), 32'd0);
    chk("rst_cdc_mode", 32'(cdc_mode), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("post_rst_cdc_rst_n", 32'(cdc_rst_n), 32'd1);
    repeat (5) tick();
    #1;
    chk("idle_cdc_valid", 32'(cdc_valid), 32'd0);

    for (int i = 0; i < 6; i++) run_job(jobs[i], i == 0);
    chk("jobs_sync_err", 32'(sync_err), 32'd0);

    // Both ports saturated, then an idle gap, then a lone port-1 job.
    do_reset();
    n0 = 8'h10; n1 = 8'h20;
    set_req(0, 1'b1, 1'b1, {n0, 8'h00});
    set_req(1, 1'b1, 1'b1, {n1, 8'h00});
    ng = 0; nr = 0; g0 = -100000; quiet = 0; upd = 1'b0; upd_p = 0;
    for (int c = 0; c < 110; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        chk("alt_one_ready", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
        upd_p = bus.req1_ready ? 1 : 0;
        if (ng == 0) g0 = cyc;
        if (ng < 7) begin
          chk("alt_port", 32'(upd_p), 32'(gprt[ng]));
          chk("alt_grant_cycle", 32'(cyc - g0), 32'(goff[ng]));
        end
        msg = upd_p ? bus.req1_data[15:8] : bus.req0_data[15:8];
        ecyc.push_back(cyc + 10);
        eprt.push_back(upd_p);
        edat.push_back({msg, crc8(msg)});
        ng++;
        upd = 1'b1;
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        if (ecyc.size() == 0) chk("alt_unexpected_rsp", 32'd1, 32'd0);
        else begin
          chk("alt_rsp_cycle", 32'(cyc), 32'(ecyc.pop_front()));
          chk("alt_rsp_port", 32'(bus.rsp1_valid), 32'(eprt.pop_front()));
          chk("alt_rsp_data", 32'(bus.rsp_data), 32'(edat.pop_front()));
          nr++;
        end
      end
      if (cyc - g0 >= 56 && cyc - g0 <= 89 &&
          (bus.req0_ready || bus.req1_ready || bus.rsp0_valid || bus.rsp1_valid))
        quiet++;
      tick();
      if (upd) begin
        upd = 1'b0;
        if (ng >= 6) begin
          set_req(0, 1'b0, 1'b0, 16'h0);
          set_req(1, 1'b0, 1'b0, 16'h0);
        end else if (upd_p == 0) begin
          n0 = n0 + 8'd1; set_req(0, 1'b1, 1'b1, {n0, 8'h00});
        end else begin
          n1 = n1 + 8'd1; set_req(1, 1'b1, 1'b1, {n1, 8'h00});
        end
      end
      if (cyc - g0 == 83) set_req(1, 1'b1, 1'b1, 16'h5A00);
    end
    chk("alt_grants", 32'(ng), 32'd7);
    chk("alt_rsps", 32'(nr), 32'd7);
    chk("idle_quiet", 32'(quiet), 32'd0);
    chk("alt_sync_err", 32'(sync_err), 32'd0);

    // Reset in the middle of a P0 frame.
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h3C00);
    #1;
    chk("mid_launch", 32'(bus.req0_ready), 32'd1);
    g = cyc;
    tick();
    set_req(0, 1'b0, 1'b0, 16'h0);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_cdc_rst_n", 32'(cdc_rst_n), 32'd0);
    chk("mid_rst_outputs", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, cdc_valid}), 32'd0);
    tick();
    #1;
    chk("mid_rst_cdc_data", 32'(cdc_data), 32'd0);
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 16'hB572);
    #1;
    chk("post_rst_launch_ready", 32'(bus.req1_ready), 32'd1);
    chk("post_rst_launch_cdc_valid", 32'(cdc_valid), 32'd1);
    g2 = cyc;
    tick();
    set_req(1, 1'b0, 1'b0, 16'h0);
    rsp0_cnt = 0; rsp1_cyc = -1; r1dat = '0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (bus.rsp0_valid) rsp0_cnt++;
      if (bus.rsp1_valid && rsp1_cyc < 0) begin rsp1_cyc = cyc; r1dat = bus.rsp_data; end
      tick();
    end
    chk("mid_no_rsp0", 32'(rsp0_cnt), 32'd0);
    chk("post_rst_rsp1_latency", 32'(rsp1_cyc - g2), 32'd10);
    chk("post_rst_rsp1_data", 32'(r1dat), 32'hA572);
    chk("mid_launch_gap", 32'(g2 - g), 32'd7);

    // Spurious codec valid mid-frame.
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'hA500);
    #1;
    chk("serr_launch", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(0, 1'b0, 1'b0, 16'h0);
    repeat (3) tick();
    #1;
    chk("serr_before", 32'(sync_err), 32'd0);
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    #1;
    chk("serr_set", 32'(sync_err), 32'd1);
    repeat (20) tick();
    #1;
    chk("serr_sticky", 32'(sync_err), 32'd1);
    do_reset();
    #1;
    chk("serr_cleared", 32'(sync_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
